cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single reorder-buffer write-back (CDB) port among NUM_REQ execution units (RS ALU, LSB, ...).
//  Each unit pushes {rob_id, value} results into its own small FIFO.
//  A round-robin scheduler drains one result per cycle into a registered CDB output that drives the ROB write port.
//  Sits between the execution units and reorder_buffer; the ROB commit-clear pulse flushes it.
// PARAMETERS
//  NUM_REQ    3   number of requesting units (2..8)
//  ROB_BITS   4   ROB index width; set from `robsize
//  DATA_W     32  result width
//  BUF_DEPTH  2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  asynchronous, active-high reset
//  rdy          in   1                  global enable; low = all state frozen
//  flush        in   1                  ROB clear; drop everything in flight
//  req_valid    in   NUM_REQ            per-unit result valid
//  req_ready    out  NUM_REQ            per-unit accept (= rdy && !fifo_full[i])
//  req_rob_id   in   NUM_REQ*ROB_BITS   packed, unit i at [i*ROB_BITS +: ROB_BITS]
//  req_value    in   NUM_REQ*DATA_W     packed, unit i at [i*DATA_W +: DATA_W]
//  cdb_valid    out  1                  registered; ROB writes this cycle
//  cdb_rob_id   out  ROB_BITS           registered
//  cdb_value    out  DATA_W             registered
//  cdb_src      out  NUM_REQ            registered one-hot of the source unit
//  idle         out  1                  all FIFOs empty and cdb_valid==0
// BEHAVIOUR
//  - Reset values: cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0. All FIFOs empty (ptrs/counts 0). rr_last=NUM_REQ-1, so unit 0 wins first.
//  - Push: at an edge with req_valid[i] && req_ready[i], the entry is written to FIFO i. req_ready uses the current count only; a full FIFO refuses even if it pops the same cycle.
//  - Arbitration (combinational, each cycle): candidates = non-empty FIFOs.
//    Grant = first candidate searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
//  - Commit of a grant at the edge when rdy=1 && !flush:
//    pop the granted head; load cdb_* from it (cdb_valid=1); rr_last <= granted index.
//    With no candidate: cdb_valid<=0; rr_last is held; cdb_rob_id/cdb_value hold their old values.
//  - Latency: result pushed at edge N is visible on cdb_* during cycle N+1 at earliest (registered output, no bypass). cdb_valid lasts exactly one cycle per result.
//  - Throughput: 1 result/cycle total. No starvation: a non-empty FIFO is granted within NUM_REQ grants.
//  - flush (sampled when rdy=1): all FIFOs emptied; cdb_valid<=0 next cycle; rr_last is held.
//    A same-cycle push is discarded. flush wins over push and pop.
//  - rdy=0: no push, pop, or pointer change; cdb_* hold their value, including cdb_valid.
//    The ROB also ignores writes while rdy=0, so the held valid is not double-counted.
//  - FIFO pointers wrap modulo BUF_DEPTH. Count width is clog2(BUF_DEPTH)+1. Simultaneous push/pop on a non-full FIFO keeps the count.
//  - rst mid-operation clears everything immediately (async), regardless of rdy.
// CONFIGURATION
//  CDB_BYPASS_EN defined:
//    if FIFO i is empty and req_valid[i] is high, unit i is a candidate that same cycle.
//    If granted, its input is sent straight to cdb_* without entering the FIFO, for 1-cycle input-to-CDB latency.
//    req_ready is unchanged.
//  CDB_BYPASS_EN undefined: only FIFO heads are candidates; latency is as stated above.
// STRUCTURE
//  - Shared constants header (const.v): `robsize, plus new `cdb_req_num (default 3), `cdb_buf_depth (default 2).
//  - Sub-module cdb_fifo (one instance per requester): push/pop/flush, outputs head data, empty, full.
//  - Top level holds the round-robin rr_last register, the grant logic and the output registers.
// TESTING
//  1. Reset -> cdb_valid=0, idle=1, req_ready=all 1 once rdy=1.
//     Single push unit1 {rob_id=5, value=0xDEAD} -> next cycle cdb_valid=1, rob_id=5, value=0xDEAD, cdb_src=3'b010.
//  2. All 3 units push in the same cycle (ids 1,2,3) -> cdb order unit0, unit1, unit2 on three consecutive cycles.
//     Then unit0 and unit2 push again -> unit0 granted before unit2 (rr_last=2).
//  3. Unit0 pushes 3 entries back-to-back with depth 2 and nothing draining it fast enough
//     -> req_ready[0]=0 while full; no entry lost or duplicated; ids come out in FIFO order.
//  4. Fill FIFOs with 4 entries, assert flush for 1 cycle together with a push on unit2
//     -> next cycle cdb_valid=0, idle=1, and the flushed ids never appear on the CDB.
//  5. Hold rdy=0 for 3 cycles while cdb_valid=1 (id 7) and FIFOs are non-empty
//     -> cdb_* stay constant and FIFO counts are unchanged; draining resumes when rdy returns to 1.
//  6. With CDB_BYPASS_EN: push on an empty unit0 {id=9} -> cdb_valid=1, id=9 at the very next edge, and FIFO0 stays empty.
//     Without the macro: the same timing as scenario 1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB write-back arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   CDB_ROB_BITS  - ROB index width (mirrors `robsize)
//   CDB_REQ_NUM   - default number of requesting units (mirrors `cdb_req_num)
//   CDB_BUF_DEPTH - default per-unit FIFO depth (mirrors `cdb_buf_depth)
//   CDB_DATA_W    - result width
//   cdb_cnt_w()   - FIFO occupancy counter width for a given depth
//   rr_index()    - round-robin search position helper
package cdb_arbiter_pkg;

  localparam int CDB_ROB_BITS  = 4;
  localparam int CDB_REQ_NUM   = 3;
  localparam int CDB_BUF_DEPTH = 2;
  localparam int CDB_DATA_W    = 32;

  // Counter must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int cdb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Index visited at search step 'step' (1..n) after the last winner 'last'.
  function automatic int unsigned rr_index(input int unsigned last,
                                           input int unsigned step,
                                           input int unsigned n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-unit result buffer: small circular FIFO with synchronous flush.
// Latency: a pushed entry becomes the head on the cycle after the push edge.
// Backpressure: full is raised at DEPTH entries; push while full and pop while empty are ignored.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data at this edge
//   push_data  - entry to write
//   pop        - drop the head at this edge
//   flush      - empty the FIFO at this edge (wins over push and pop)
//   head       - current head entry (meaningful only when !empty)
//   empty/full - occupancy flags from the current count
module cdb_arbiter_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cdb_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single ROB write-back (CDB) port among NUM_REQ execution units.
// Latency: FIFO entry to cdb_* is one registered stage; push edge N appears in cycle N+1 at the earliest.
// Backpressure: req_ready[i] = rdy && FIFO i not full; rdy low freezes everything including cdb_*.
//
// Optional feature: define CDB_BYPASS_EN to let an empty unit with req_valid compete
// in the same cycle and go straight to cdb_* without entering its FIFO.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   rdy                      - global enable (low = all state frozen)
//   flush                    - ROB clear; drops every buffered result and any same-cycle push
//   req_valid/req_ready      - per-unit handshake
//   req_rob_id / req_value   - packed per-unit results, unit i at [i*W +: W]
//   cdb_valid/rob_id/value   - registered ROB write port
//   cdb_src                  - registered one-hot of the unit that produced cdb_*
//   idle                     - all FIFOs empty and no result on the CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = CDB_REQ_NUM,
  parameter int ROB_BITS  = CDB_ROB_BITS,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_BITS-1:0]  req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0]    req_value,
  output logic                         cdb_valid,
  output logic [ROB_BITS-1:0]          cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_value,
  output logic [NUM_REQ-1:0]           cdb_src,
  output logic                         idle
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int ENT_W = ROB_BITS + DATA_W;
  localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] fifo_full;
  logic [NUM_REQ-1:0] fifo_push;
  logic [NUM_REQ-1:0] fifo_pop;
  logic [ENT_W-1:0]   fifo_head [NUM_REQ];
  logic [ENT_W-1:0]   req_ent   [NUM_REQ];
  logic               fifo_flush;

  logic [NUM_REQ-1:0] cand;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   search_idx;
  logic               gnt_bypass;
  logic [ENT_W-1:0]   gnt_ent;
  logic               commit;

  logic [IDX_W-1:0]   rr_last;

  // A result leaves its buffer only when the pipeline is enabled and not being cleared.
  assign commit     = rdy && !flush;
  assign fifo_flush = rdy && flush;

  // ---------------------------------------------------------------------------
  // Per-unit buffers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unit
    assign req_ent[i]   = {req_rob_id[i*ROB_BITS +: ROB_BITS], req_value[i*DATA_W +: DATA_W]};
    // Ready looks only at the current count: a full FIFO refuses even if it pops this edge.
    assign req_ready[i] = rdy && !fifo_full[i];

    cdb_arbiter_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[i]),
      .push_data (req_ent[i]),
      .pop       (fifo_pop[i]),
      .flush     (fifo_flush),
      .head      (fifo_head[i]),
      .empty     (fifo_empty[i]),
      .full      (fifo_full[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Candidate set
  // ---------------------------------------------------------------------------
`ifdef CDB_BYPASS_EN
  // An empty unit presenting a result competes directly; empty implies not full,
  // so such a unit is always ready whenever rdy is high.
  assign cand       = ~fifo_empty | (fifo_empty & req_valid);
  assign gnt_bypass = gnt_found && fifo_empty[gnt_idx];
`else
  assign cand       = ~fifo_empty;
  assign gnt_bypass = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin grant: first candidate after the last winner, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    search_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      search_idx = IDX_W'(rr_index(32'(rr_last), k, NUM_REQ));
      if (!gnt_found && cand[search_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = search_idx;
      end
    end
  end

  always_comb begin
    gnt_ent = fifo_head[gnt_idx];
    if (gnt_bypass) gnt_ent = req_ent[gnt_idx];
  end

  // ---------------------------------------------------------------------------
  // FIFO push/pop strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_push = '0;
    fifo_pop  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // A bypassed result goes straight to the CDB and must not also be buffered.
      fifo_push[i] = commit && req_valid[i] && req_ready[i] &&
                     !(gnt_bypass && (gnt_idx == IDX_W'(i)));
      fifo_pop[i]  = commit && gnt_found && !gnt_bypass && (gnt_idx == IDX_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Registered CDB output and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
      rr_last    <= RR_INIT;
    end else if (rdy) begin
      if (flush) begin
        // rr_last is deliberately kept so fairness carries across a flush.
        cdb_valid <= 1'b0;
      end else if (gnt_found) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= gnt_ent[ENT_W-1 -: ROB_BITS];
        cdb_value  <= gnt_ent[DATA_W-1:0];
        cdb_src    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
        rr_last    <= gnt_idx;
      end else begin
        // Payload is left as-is; only the valid drops.
        cdb_valid <= 1'b0;
      end
    end
  end

  assign idle = (&fifo_empty) && !cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_rob_id;
  logic [95:0] req_value;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [2:0]  cdb_src;
  logic        idle;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ   (3),
    .ROB_BITS  (4),
    .DATA_W    (32),
    .BUF_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rob_id (req_rob_id),
    .req_value  (req_value),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src),
    .idle       (idle)
  );

  // One clock cycle of stimulus with the outputs expected around it.
  typedef struct packed {
    logic            do_rst;
    logic            rdy;
    logic            flush;
    logic [2:0]      vld;
    logic [2:0][3:0] ids;
    logic [2:0]      exp_ready;   // req_ready before the edge
    logic            exp_vld;     // cdb_valid after the edge
    logic [3:0]      exp_id;      // cdb_rob_id after the edge (held when not valid)
    logic [2:0]      exp_src;     // cdb_src after the edge, checked when valid
    logic            exp_idle;    // idle after the edge
  } row_t;

  row_t rows[$];
  int   checks = 0;
  int   errors = 0;
  int   row_no = 0;

  // Scoreboard: results each unit has handed over and not yet seen on the CDB.
  logic [35:0] sb_q0[$];
  logic [35:0] sb_q1[$];
  logic [35:0] sb_q2[$];

  function automatic logic [31:0] val_of(input logic [3:0] id);
    return 32'h0000_DEA8 + 32'(id);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row_no, act, exp);
    end
  endtask

  task automatic add(input int rs, input int rd, input int fl, input int v,
                     input int i0, input int i1, input int i2,
                     input int er, input int ev, input int eid, input int es, input int eidle);
    row_t r;
    r.do_rst    = rs[0];
    r.rdy       = rd[0];
    r.flush     = fl[0];
    r.vld       = 3'(v);
    r.ids[0]    = 4'(i0);
    r.ids[1]    = 4'(i1);
    r.ids[2]    = 4'(i2);
    r.exp_ready = 3'(er);
    r.exp_vld   = ev[0];
    r.exp_id    = 4'(eid);
    r.exp_src   = 3'(es);
    r.exp_idle  = eidle[0];
    rows.push_back(r);
  endtask

  task automatic sb_push(input int u, input logic [35:0] ent);
    case (u)
      0:       sb_q0.push_back(ent);
      1:       sb_q1.push_back(ent);
      default: sb_q2.push_back(ent);
    endcase
  endtask

  task automatic sb_compare();
    int          u;
    int          depth;
    logic [35:0] ent;
    case (cdb_src)
      3'b001:  u = 0;
      3'b010:  u = 1;
      3'b100:  u = 2;
      default: u = -1;
    endcase
    checks++;
    if (u < 0) begin
      errors++;
      $display("FAIL sb_src row %0d: got %b expected one-hot", row_no, cdb_src);
      return;
    end
    depth = (u == 0) ? sb_q0.size() : (u == 1) ? sb_q1.size() : sb_q2.size();
    if (depth == 0) begin
      errors++;
      $display("FAIL sb_unexpected row %0d: got id %h from unit %0d expected nothing outstanding",
               row_no, cdb_rob_id, u);
      return;
    end
    case (u)
      0:       ent = sb_q0.pop_front();
      1:       ent = sb_q1.pop_front();
      default: ent = sb_q2.pop_front();
    endcase
    check("sb_rob_id", 32'(cdb_rob_id), 32'(ent[35:32]));
    check("sb_value", cdb_value, ent[31:0]);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_rob_id", 32'(cdb_rob_id), 32'd0);
    check("rst_cdb_value", cdb_value, 32'd0);
    check("rst_cdb_src", 32'(cdb_src), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    #1;
    rst = 1'b0;
    sb_q0.delete();
    sb_q1.delete();
    sb_q2.delete();
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_row(input row_t r);
    logic [2:0] accepted;
    if (r.do_rst) apply_reset();
    rdy       = r.rdy;
    flush     = r.flush;
    req_valid = r.vld;
    for (int u = 0; u < 3; u++) begin
      req_rob_id[u*4 +: 4]   = r.ids[u];
      req_value[u*32 +: 32]  = val_of(r.ids[u]);
    end
    #1;
    check("req_ready", 32'(req_ready), 32'(r.exp_ready));
    accepted = r.vld & r.exp_ready;
    @(posedge clk);
    #1;
    check("cdb_valid", 32'(cdb_valid), 32'(r.exp_vld));
    check("cdb_rob_id", 32'(cdb_rob_id), 32'(r.exp_id));
    if (r.exp_vld) check("cdb_src", 32'(cdb_src), 32'(r.exp_src));
    check("idle", 32'(idle), 32'(r.exp_idle));
    if (r.rdy) begin
      if (r.flush) begin
        sb_q0.delete();
        sb_q1.delete();
        sb_q2.delete();
      end else begin
        for (int u = 0; u < 3; u++)
          if (accepted[u]) sb_push(u, {r.ids[u], val_of(r.ids[u])});
        if (cdb_valid) sb_compare();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    rdy        = 1'b0;
    flush      = 1'b0;
    req_valid  = '0;
    req_rob_id = '0;
    req_value  = '0;

    //   rst rdy fl vld    i0 i1 i2  ready  vld id src    idle
`ifndef CDB_BYPASS_EN
    // 1: single push on unit1 appears one cycle later with value 0xDEAD
    add(1, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 0,  3'b000, 1);
    add(0, 1, 0, 3'b010, 0, 5, 0,  3'b111, 0, 0,  3'b000, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 5,  3'b010, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 5,  3'b000, 1);
    // 2: three simultaneous pushes drain 0,1,2; then unit0 beats unit2
    add(1, 1, 0, 3'b111, 1, 2, 3,  3'b111, 0, 0,  3'b000, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 1,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 2,  3'b010, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 3,  3'b100, 0);
    add(0, 1, 0, 3'b101, 4, 0, 6,  3'b111, 0, 3,  3'b000, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 4,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 6,  3'b100, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 6,  3'b000, 1);
    // 3: unit0 fills while others take grants; id4 waits until a slot frees
    add(1, 1, 0, 3'b111, 1, 8, 12, 3'b111, 0, 0,  3'b000, 0);
    add(0, 1, 0, 3'b001, 2, 0, 0,  3'b111, 1, 1,  3'b001, 0);
    add(0, 1, 0, 3'b001, 3, 0, 0,  3'b111, 1, 8,  3'b010, 0);
    add(0, 1, 0, 3'b001, 4, 0, 0,  3'b110, 1, 12, 3'b100, 0);
    add(0, 1, 0, 3'b001, 4, 0, 0,  3'b110, 1, 2,  3'b001, 0);
    add(0, 1, 0, 3'b001, 4, 0, 0,  3'b111, 1, 3,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 4,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 4,  3'b000, 1);
    // 4: four buffered entries plus a same-cycle push on unit2 are flushed;
    //    the round-robin pointer survives (unit1 wins after unit0 last won)
    add(1, 1, 0, 3'b111, 1, 2, 3,  3'b111, 0, 0,  3'b000, 0);
    add(0, 1, 0, 3'b011, 4, 5, 0,  3'b111, 1, 1,  3'b001, 0);
    add(0, 1, 1, 3'b100, 0, 0, 6,  3'b101, 0, 1,  3'b000, 1);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 1,  3'b000, 1);
    add(0, 1, 0, 3'b011, 10, 11, 0, 3'b111, 0, 1, 3'b000, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 11, 3'b010, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 10, 3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 10, 3'b000, 1);
    // 5: rdy low for three cycles holds id7 on the CDB and freezes the FIFOs
    add(1, 1, 0, 3'b111, 7, 8, 9,  3'b111, 0, 0,  3'b000, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 7,  3'b001, 0);
    add(0, 0, 0, 3'b010, 0, 10, 0, 3'b000, 1, 7,  3'b001, 0);
    add(0, 0, 0, 3'b000, 0, 0, 0,  3'b000, 1, 7,  3'b001, 0);
    add(0, 0, 0, 3'b000, 0, 0, 0,  3'b000, 1, 7,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 8,  3'b010, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 9,  3'b100, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 9,  3'b000, 1);
    // 6 (no bypass): push to empty unit0 follows the registered latency
    add(1, 1, 0, 3'b001, 9, 0, 0,  3'b111, 0, 0,  3'b000, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 1, 9,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 9,  3'b000, 1);
`else
    // 6 (bypass): push to empty unit0 reaches the CDB at the very next edge
    //             and never lands in FIFO0, so it is not replayed
    add(1, 1, 0, 3'b001, 9, 0, 0,  3'b111, 1, 9,  3'b001, 0);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 9,  3'b000, 1);
    add(0, 1, 0, 3'b000, 0, 0, 0,  3'b111, 0, 9,  3'b000, 1);
`endif

    @(negedge clk);
    foreach (rows[n]) begin
      row_no = n;
      run_row(rows[n]);
    end

    // Every accepted result must have reached the CDB exactly once.
    row_no = rows.size();
    check("sb_leftover", 32'(sb_q0.size() + sb_q1.size() + sb_q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
